out_display_driver: RTL and testbench
=====================================

Name: out_display_driver

Overview:
- Downstream of the OUT register; consumes its 4-bit output bus and the OUT load strobe.
- Keeps a history of the most recent NUM_DIGITS values written by OUT instructions in a shift buffer. The newest value is always digit 0.
- Time-multiplexes the history onto a common-anode seven-segment display with active-low segments and anodes.
- Flags buffer overflow, and shows a halt indicator on digit 0's decimal point.

Parameters:
- NUM_DIGITS, 4, number of display digits / history depth (2..8).
- REFRESH_DIV, 4, clock cycles each digit stays selected (>=1); kept small for simulation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- out_value  input  4  data bus from the OUT register.
- out_strobe  input  1  OUT register load enable (the same control that loads OUT).
- hlt  input  1  halt control from the sequencer.
- clear  input  1  synchronous clear of the history buffer.
- seg  output  7  active-low segments; seg[6]=g ... seg[0]=a.
- dp  output  1  active-low decimal point.
- an  output  NUM_DIGITS  active-low digit enables; an[i] drives digit i.
- digit_count  output  4  number of valid history entries, 0..NUM_DIGITS.
- overflow  output  1  sticky flag: a value was shifted out of the buffer.

Behaviour:
- Reset (async, active-high):
  - All buffer entries = 0, count = 0, overflow = 0, capture_pending = 0.
  - Prescaler = 0, digit index = 0.
  - seg = 7'h7F, dp = 1, an = all ones.
- Capture (one-cycle latency):
  - out_strobe sampled high at edge N sets capture_pending.
  - At edge N+1, out_value is shifted in: buf[i] <= buf[i-1], buf[0] <= out_value.
  - This delay allows for the OUT register updating on the same edge as the strobe.
  - Back-to-back strobes each capture, one per cycle, with no loss.
- Count: increments on capture and saturates at NUM_DIGITS.
- Overflow: a capture while count == NUM_DIGITS discards buf[NUM_DIGITS-1] and sets overflow. Overflow clears only on reset or clear.
- Clear:
  - Next edge: buffer = 0, count = 0, overflow = 0, capture_pending = 0.
  - Clear takes priority over a capture pending in the same cycle; the pending value is dropped.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1.
  - On the edge where the prescaler wraps, digit index advances and wraps from NUM_DIGITS-1 to 0.
  - The scan runs continuously, independent of capture, clear and hlt.
- Outputs (registered; they reflect digit index and buffer contents one cycle late):
  - If index < count: an = one-hot low at index, seg = hex decode of buf[index].
  - Otherwise: an = all ones, seg = 7'h7F (unused digits blank).
  - dp = 0 only when index == 0 and hlt == 1 and count > 0; otherwise dp = 1.
- Hex decode (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex)
- Width rule: digit_count is zero-extended to 4 bits.
- Reset asserted mid-scan or mid-capture: immediate return to the reset state. A pending capture is lost.

Decomposition:
- Shared package cpu_disp_pkg:
  - SEG_BLANK = 7'h7F.
  - A 16-entry seven-segment constant table.
  - Typedef seg7_t (logic [6:0]).
- Sub-module hex_to_seg7: combinational 4-bit to seg7_t lookup, instantiated once on the selected digit.
- Prescaler, scan counter, history buffer and output registers live in out_display_driver.

Test Plan:
- Reset: hold reset → an=4'b1111, seg=7'h7F, dp=1, digit_count=0, overflow=0 throughout; deassert, still blank.
- Single capture: out_value=4'h1 with a one-cycle out_strobe → digit_count=1 two edges later. Only when index 0 is scanned: an=4'b1110, seg=7'h79. Other slots blank.
- Fill and overflow: capture 1,8,A,3,5 → buf = {5,3,A,8} with digit0=5 (seg 7'h12) and digit3=8 (seg 7'h00); digit_count=4, overflow=1.
- Clear vs capture: assert clear in the cycle capture_pending is set (value 4'h7) → count=0, all blank, 4'h7 never displayed, overflow=0.
- Halt indicator: count=1, hlt=1 → dp=0 only while an=4'b1110. hlt=0 or count=0 → dp stays 1.
- Reset mid-operation: assert reset during scan index 2 after 3 captures → outputs blank asynchronously (before the next clk edge). After release, the scan restarts at index 0 and count=0.

Source files
------------

// File: rtl/cpu_disp_pkg.sv
// Shared display types and constants for the OUT display driver.
// Provides seg7_t, the blank pattern and the active-low hex segment table.
package cpu_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam seg7_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Ports: value (4-bit hex digit) -> seg (seg7_t, seg[6]=g .. seg[0]=a).
module hex_to_seg7
  import cpu_disp_pkg::*;
(
  input  logic [3:0] value,
  output seg7_t      seg
);

  assign seg = SEG_TABLE[value];

endmodule

// File: rtl/out_display_driver.sv
// History buffer of OUT writes, time-multiplexed onto a common-anode display.
// Ports: clk, reset (async high), out_value/out_strobe (OUT reg), hlt, clear;
//        seg/dp/an (active low), digit_count, overflow (sticky).
module out_display_driver
  import cpu_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            out_value,
  input  logic                  out_strobe,
  input  logic                  hlt,
  input  logic                  clear,
  output seg7_t                 seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [3:0]            digit_count,
  output logic                  overflow
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0]    FULL  = 4'(NUM_DIGITS);
  localparam logic [PW-1:0] P_TOP = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_TOP = IW'(NUM_DIGITS - 1);

  logic [3:0]    hist [NUM_DIGITS];
  logic [3:0]    count;
  logic          pending;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  seg7_t         dec;
  logic          active;
  logic          dot_on;

  hex_to_seg7 u_dec (
    .value (hist[idx]),
    .seg   (dec)
  );

  assign active      = 4'(idx) < count;
  assign dot_on      = (idx == '0) && hlt && (count != 4'd0);
  assign digit_count = count;

  // The OUT register loads on the strobe edge, so the value
  // is taken one edge later via pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= 4'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
      pending  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= 4'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
      pending  <= 1'b0;
    end else begin
      pending <= out_strobe;
      if (pending) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--)
          hist[i] <= hist[i-1];
        hist[0] <= out_value;
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == P_TOP) begin
      presc <= '0;
      idx   <= (idx == I_TOP) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= active ? dec : SEG_BLANK;
      an  <= active ? ~(NUM_DIGITS'(1) << idx) : '1;
      dp  <= ~dot_on;
    end
  end

endmodule

// File: tb/tb_out_display_driver.sv
// Self-checking bench for out_display_driver.
// Queue-based history model plus literal spot checks.
module tb_out_display_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    out_value = 4'd0;
  logic          out_strobe = 1'b0;
  logic          hlt = 1'b0;
  logic          clear = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic [3:0]    digit_count;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  out_display_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .out_value   (out_value),
    .out_strobe  (out_strobe),
    .hlt         (hlt),
    .clear       (clear),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .digit_count (digit_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: q holds history newest-first; cyc counts edges since reset.
  logic [3:0]    q [$];
  bit            m_pend = 0;
  bit            m_ovf = 0;
  int            cyc = 0;
  logic [6:0]    e_seg = 7'h7F;
  logic [ND-1:0] e_an = '1;
  logic          e_dp = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_pend = 0;
      m_ovf  = 0;
      cyc    = 0;
      e_seg  = 7'h7F;
      e_an   = '1;
      e_dp   = 1'b1;
    end else begin
      int k;
      k = (cyc / RD) % ND;
      if (k < q.size()) begin
        e_an  = ~(ND'(1) << k);
        e_seg = tbl[q[k]];
      end else begin
        e_an  = '1;
        e_seg = 7'h7F;
      end
      e_dp = !(k == 0 && hlt && q.size() > 0);
      cyc++;
      if (clear) begin
        q.delete();
        m_pend = 0;
        m_ovf  = 0;
      end else begin
        if (m_pend) begin
          q.push_front(out_value);
          if (q.size() > ND) begin
            void'(q.pop_back());
            m_ovf = 1;
          end
        end
        m_pend = out_strobe;
      end
    end
  end

  task automatic check(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("seg", 8'(seg), 8'(e_seg));
    check("an", 8'(an), 8'(e_an));
    check("dp", 8'(dp), 8'(e_dp));
    check("count", 8'(digit_count), 8'(q.size()));
    check("ovf", 8'(overflow), 8'(m_ovf));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [ND-1:0] t,
                         input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an === t) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout an=%b required=%b",
               nm, an, t);
    end
  endtask

  // OUT register style: strobe first, value appears one cycle later.
  task automatic capture_seq(input logic [3:0] v [$]);
    @(negedge clk);
    out_strobe = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      out_value  = v[i];
      out_strobe = (i < v.size() - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle(4);
    check("rst_an", 8'(an), 8'h0F);
    check("rst_seg", 8'(seg), 8'h7F);
    check("rst_cnt", 8'(digit_count), 8'h00);
    reset = 1'b0;
    idle(10);
    check("post_rst_an", 8'(an), 8'h0F);

    // single capture
    @(negedge clk);
    out_strobe = 1'b1;
    @(posedge clk);
    #1 check("cnt_lat0", 8'(digit_count), 8'h00);
    @(negedge clk);
    out_strobe = 1'b0;
    out_value  = 4'h1;
    @(posedge clk);
    #1 check("cnt_lat1", 8'(digit_count), 8'h01);
    wait_an(4'b1110, "wait_d0_single");
    check("single_seg", 8'(seg), 8'h79);
    idle(20);

    // halt indicator
    hlt = 1'b1;
    wait_an(4'b1110, "wait_d0_hlt");
    check("hlt_dp", 8'(dp), 8'h00);
    idle(20);
    hlt = 1'b0;
    idle(20);

    // fill and overflow
    capture_seq('{4'h8, 4'hA, 4'h3, 4'h5});
    idle(3);
    check("fill_cnt", 8'(digit_count), 8'h04);
    check("fill_ovf", 8'(overflow), 8'h01);
    wait_an(4'b1110, "wait_d0_fill");
    check("fill_d0", 8'(seg), 8'h12);
    wait_an(4'b0111, "wait_d3_fill");
    check("fill_d3", 8'(seg), 8'h00);
    idle(20);

    // clear wins over pending capture of 7
    @(negedge clk);
    out_strobe = 1'b1;
    @(negedge clk);
    out_strobe = 1'b0;
    out_value  = 4'h7;
    clear      = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_cnt", 8'(digit_count), 8'h00);
    check("clr_ovf", 8'(overflow), 8'h00);
    hlt = 1'b1;
    idle(40);
    check("clr_blank", 8'(an), 8'h0F);
    check("clr_dp", 8'(dp), 8'h01);
    hlt = 1'b0;

    // reset during scan of index 2
    capture_seq('{4'h2, 4'h4, 4'h6});
    idle(2);
    wait_an(4'b1011, "wait_d2");
    check("d2_seg", 8'(seg), 8'h24);
    #2 reset = 1'b1;
    #1;
    check("arst_an", 8'(an), 8'h0F);
    check("arst_seg", 8'(seg), 8'h7F);
    check("arst_dp", 8'(dp), 8'h01);
    check("arst_cnt", 8'(digit_count), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    capture_seq('{4'h9});
    wait_an(4'b1110, "wait_d0_after");
    check("after_seg", 8'(seg), 8'h10);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
